mixed_precision_alu_scheduler: RTL and testbench

MIXED_PRECISION_ALU_SCHEDULER -- requirements
Module: mixed_precision_alu_scheduler

---
 rtl/mixed_precision_alu_scheduler.sv | 242 ++++++++++++++++++++++++
 tb/tb_mixed_precision_alu_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mixed_precision_alu_scheduler.sv
// ---------------------------------------------------------------------------
// mixed_precision_alu_scheduler
//
// Shares one fixed-latency 16-bit ALU among N_REQ requesters. A round-robin
// arbiter picks at most one request per cycle. The winner's operands are
// registered onto the ALU port. A {valid, id, err} tag follows each accepted
// operation through a shift pipeline, so responses come back in acceptance
// order and line up with the ALU's result. A divide by zero is never issued
// to the ALU. Its tag carries err=1 and the response reports 16'hFFFF.
//
// Parameters
//   N_REQ      number of requesters (2..8)
//   ALU_LAT    ALU cycles from operand sample to result
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   en                       grant enable; low drains in-flight work
//   req_valid / req_ready    per-requester handshake (ready is one-hot or 0)
//   req_op/req_a/req_b       packed per-requester payload
//                            (op: 00 add, 01 mul, 10 sub, 11 div)
//   alu_op/alu_a/alu_b       registered operands to the shared ALU
//   alu_result               ALU result, ALU_LAT cycles after sampling
//   resp_valid/id/data/err   one-cycle response strobe with payload
//   busy                     work in flight or FSM not idle
// ---------------------------------------------------------------------------
module mixed_precision_alu_scheduler #(
    parameter int N_REQ   = 4,
    parameter int ALU_LAT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*2-1:0]        req_op,
    input  logic [N_REQ*16-1:0]       req_a,
    input  logic [N_REQ*16-1:0]       req_b,
    output logic [1:0]                alu_op,
    output logic [15:0]               alu_a,
    output logic [15:0]               alu_b,
    input  logic [15:0]               alu_result,
    output logic                      resp_valid,
    output logic [$clog2(N_REQ)-1:0]  resp_id,
    output logic [15:0]               resp_data,
    output logic                      resp_err,
    output logic                      busy
);

    localparam int IDW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
        logic           err;
    } tag_t;

    state_t         state_r;
    logic [IDW-1:0] last_grant_r;
    logic [1:0]     alu_op_r;
    logic [15:0]    alu_a_r;
    logic [15:0]    alu_b_r;
    tag_t           issue_tag_r;
    tag_t           tag_pipe_r [ALU_LAT+1];

    logic [1:0]     op_arr_s [N_REQ];
    logic [15:0]    a_arr_s  [N_REQ];
    logic [15:0]    b_arr_s  [N_REQ];

    logic           grant_found_s;
    logic [IDW-1:0] grant_idx_s;
    int             cand_sum_s;
    logic [IDW-1:0] cand_idx_s;
    logic           any_valid_s;
    logic           accept_s;
    logic [1:0]     win_op_s;
    logic [15:0]    win_a_s;
    logic [15:0]    win_b_s;
    logic           div0_s;
    logic [N_REQ-1:0] req_ready_s;
    logic           inflight_next_s;
    logic           busy_s;
    logic           resp_valid_s;
    logic [IDW-1:0] resp_id_s;
    logic [15:0]    resp_data_s;
    logic           resp_err_s;

    // Split the packed request buses into per-requester arrays.
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign op_arr_s[g] = req_op[2*g +: 2];
        assign a_arr_s[g]  = req_a[16*g +: 16];
        assign b_arr_s[g]  = req_b[16*g +: 16];
    end

    assign any_valid_s = |req_valid;
    assign win_op_s    = op_arr_s[grant_idx_s];
    assign win_a_s     = a_arr_s[grant_idx_s];
    assign win_b_s     = b_arr_s[grant_idx_s];
    assign div0_s      = (win_op_s == 2'b11) && (win_b_s == 16'd0);

    // Round-robin search: first valid requester after last_grant, wrapping.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_sum_s    = 0;
        cand_idx_s    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_sum_s = int'(last_grant_r) + k;
            if (cand_sum_s >= N_REQ) begin
                cand_sum_s = cand_sum_s - N_REQ;
            end else begin
                cand_sum_s = cand_sum_s;
            end
            cand_idx_s = cand_sum_s[IDW-1:0];
            if (!grant_found_s && req_valid[cand_idx_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_idx_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Only the ISSUE state with enable may hand out the one-hot grant.
    assign accept_s = (state_r == ST_ISSUE) && en && grant_found_s;

    // One-hot ready for the arbitration winner.
    always_comb begin
        req_ready_s = '0;
        if (accept_s) begin
            req_ready_s[grant_idx_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    // Work that will still be in flight after the coming edge. The last
    // tag stage is excluded because it retires this cycle. This lets the FSM
    // reach IDLE on the same edge the final response retires.
    always_comb begin
        inflight_next_s = issue_tag_r.valid;
        for (int j = 0; j < ALU_LAT; j++) begin
            inflight_next_s = inflight_next_s | tag_pipe_r[j].valid;
        end
        busy_s = inflight_next_s | tag_pipe_r[ALU_LAT].valid | (state_r != ST_IDLE);
    end

    // Response decode from the oldest tag; payload forced to zero when idle.
    always_comb begin
        resp_valid_s = tag_pipe_r[ALU_LAT].valid;
        resp_id_s    = '0;
        resp_data_s  = 16'd0;
        resp_err_s   = 1'b0;
        if (tag_pipe_r[ALU_LAT].valid) begin
            resp_id_s   = tag_pipe_r[ALU_LAT].id;
            resp_err_s  = tag_pipe_r[ALU_LAT].err;
            resp_data_s = tag_pipe_r[ALU_LAT].err ? 16'hFFFF : alu_result;
        end else begin
            resp_id_s   = '0;
            resp_err_s  = 1'b0;
            resp_data_s = 16'd0;
        end
    end

    // Scheduler FSM: IDLE -> ISSUE on demand, DRAIN when disabled or empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (en && any_valid_s) state_r <= ST_ISSUE;
                    else                   state_r <= ST_IDLE;
                end
                ST_ISSUE: begin
                    if (!en)                                  state_r <= ST_DRAIN;
                    else if (!any_valid_s && !inflight_next_s) state_r <= ST_DRAIN;
                    else                                      state_r <= ST_ISSUE;
                end
                ST_DRAIN: begin
                    if (en && any_valid_s)   state_r <= ST_ISSUE;
                    else if (!inflight_next_s) state_r <= ST_IDLE;
                    else                     state_r <= ST_DRAIN;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Grant pointer, ALU operand registers and the tag shift pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= IDW'(N_REQ - 1);
            alu_op_r     <= 2'b00;
            alu_a_r      <= 16'd0;
            alu_b_r      <= 16'd0;
            issue_tag_r  <= '0;
            for (int j = 0; j <= ALU_LAT; j++) begin
                tag_pipe_r[j] <= '0;
            end
        end else begin
            if (accept_s) begin
                last_grant_r <= grant_idx_s;
            end else begin
                last_grant_r <= last_grant_r;
            end
            // A divide by zero keeps the ALU port quiet; the tag still travels.
            if (accept_s && !div0_s) begin
                alu_op_r <= win_op_s;
                alu_a_r  <= win_a_s;
                alu_b_r  <= win_b_s;
            end else begin
                alu_op_r <= 2'b00;
                alu_a_r  <= 16'd0;
                alu_b_r  <= 16'd0;
            end
            issue_tag_r.valid <= accept_s;
            issue_tag_r.id    <= accept_s ? grant_idx_s : '0;
            issue_tag_r.err   <= accept_s & div0_s;
            tag_pipe_r[0]     <= issue_tag_r;
            for (int j = 1; j <= ALU_LAT; j++) begin
                tag_pipe_r[j] <= tag_pipe_r[j-1];
            end
        end
    end

    assign req_ready  = req_ready_s;
    assign alu_op     = alu_op_r;
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign resp_valid = resp_valid_s;
    assign resp_id    = resp_id_s;
    assign resp_data  = resp_data_s;
    assign resp_err   = resp_err_s;
    assign busy       = busy_s;

endmodule

// File: tb/tb_mixed_precision_alu_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for mixed_precision_alu_scheduler.
// A stub ALU with ALU_LAT cycles of latency is attached to the DUT.
// A reference model predicts each cycle's outputs. It keeps the scheduler
// mode, the grant pointer and a queue of pending responses, each with the
// cycle in which it is due. Directed scenarios run first, then random
// traffic.
// ---------------------------------------------------------------------------
module tb_mixed_precision_alu_scheduler;

    localparam int N_REQ   = 4;
    localparam int ALU_LAT = 2;
    localparam int IDW     = $clog2(N_REQ);
    localparam int M_IDLE  = 0;
    localparam int M_ISSUE = 1;
    localparam int M_DRAIN = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*2-1:0]  req_op;
    logic [N_REQ*16-1:0] req_a;
    logic [N_REQ*16-1:0] req_b;
    logic [1:0]          alu_op;
    logic [15:0]         alu_a;
    logic [15:0]         alu_b;
    logic [15:0]         alu_result;
    logic                resp_valid;
    logic [IDW-1:0]      resp_id;
    logic [15:0]         resp_data;
    logic                resp_err;
    logic                busy;

    always #5 clk = ~clk;

    mixed_precision_alu_scheduler #(.N_REQ(N_REQ), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
        .resp_err(resp_err), .busy(busy)
    );

    function automatic logic [15:0] alu_f(input logic [1:0] f_op, input logic [15:0] f_a,
                                          input logic [15:0] f_b);
        logic [15:0] r;
        case (f_op)
            2'b00:   r = f_a + f_b;
            2'b01:   r = f_a * f_b;
            2'b10:   r = f_a - f_b;
            default: r = (f_b == 16'd0) ? 16'd0 : f_a / f_b;
        endcase
        return r;
    endfunction

    // Stub ALU: samples operands each edge; the result appears ALU_LAT edges later.
    logic [15:0] alu_pipe [ALU_LAT+1];
    always @(posedge clk) begin
        alu_pipe[0] <= alu_f(alu_op, alu_a, alu_b);
        for (int j = 1; j <= ALU_LAT; j++) alu_pipe[j] <= alu_pipe[j-1];
    end
    assign alu_result = alu_pipe[ALU_LAT];

    // Requester-side stimulus variables
    logic        v  [N_REQ];
    logic [1:0]  op [N_REQ];
    logic [15:0] a  [N_REQ];
    logic [15:0] b  [N_REQ];

    always_comb begin
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_valid[i]       = v[i];
            req_op[2*i +: 2]   = op[i];
            req_a[16*i +: 16]  = a[i];
            req_b[16*i +: 16]  = b[i];
        end
    end

    // Reference model state
    typedef struct {
        int          id;
        int          err;
        logic [15:0] data;
        int          due;
    } rsp_t;

    rsp_t        q[$];
    int          mode;
    int          last;
    int          cyc;
    int          acc_id;
    bit          checking;
    logic [1:0]  e_op;
    logic [15:0] e_a;
    logic [15:0] e_b;
    int          compared;
    int          mismatched;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input int lg);
        for (int off = 1; off <= N_REQ; off++) begin
            if (v[(lg + off) % N_REQ]) return (lg + off) % N_REQ;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        int               pick;
        logic [N_REQ-1:0] one;
        logic [N_REQ-1:0] er;
        one  = {{(N_REQ-1){1'b0}}, 1'b1};
        pick = rr_pick(last);
        er   = '0;
        if (mode == M_ISSUE && en && pick >= 0) er = one << pick;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("alu_op", 32'(alu_op), 32'(e_op));
        chk("alu_a", 32'(alu_a), 32'(e_a));
        chk("alu_b", 32'(alu_b), 32'(e_b));
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("resp_valid", 32'(resp_valid), 32'd1);
            chk("resp_id", 32'(resp_id), 32'(q[0].id));
            chk("resp_data", 32'(resp_data), 32'(q[0].data));
            chk("resp_err", 32'(resp_err), 32'(q[0].err));
        end else begin
            chk("resp_valid", 32'(resp_valid), 32'd0);
            chk("resp_id_idle", 32'(resp_id), 32'd0);
            chk("resp_data_idle", 32'(resp_data), 32'd0);
            chk("resp_err_idle", 32'(resp_err), 32'd0);
        end
        chk("busy", 32'(busy), (mode != M_IDLE || q.size() > 0) ? 32'd1 : 32'd0);
    endtask

    task automatic model_edge();
        int   c;
        int   pick;
        bit   anyv;
        bit   infl;
        bit   div0;
        rsp_t r;
        c      = cyc;
        acc_id = -1;
        if (rst) begin
            q.delete();
            mode = M_IDLE;
            last = N_REQ - 1;
            e_op = 2'b00; e_a = 16'd0; e_b = 16'd0;
        end else begin
            anyv = 1'b0;
            for (int i = 0; i < N_REQ; i++) anyv |= v[i];
            infl = 1'b0;
            foreach (q[j]) if (q[j].due > c) infl = 1'b1;
            pick = rr_pick(last);
            e_op = 2'b00; e_a = 16'd0; e_b = 16'd0;
            if (mode == M_ISSUE && en && pick >= 0) begin
                acc_id = pick;
                div0   = (op[pick] == 2'b11) && (b[pick] == 16'd0);
                r.id   = pick;
                r.err  = div0 ? 1 : 0;
                r.data = div0 ? 16'hFFFF : alu_f(op[pick], a[pick], b[pick]);
                r.due  = c + 1 + ALU_LAT + 1;
                q.push_back(r);
                last = pick;
                if (!div0) begin
                    e_op = op[pick]; e_a = a[pick]; e_b = b[pick];
                end
            end
            case (mode)
                M_IDLE:  if (en && anyv) mode = M_ISSUE;
                M_ISSUE: if (!en || (!anyv && !infl)) mode = M_DRAIN;
                default: begin
                    if (en && anyv) mode = M_ISSUE;
                    else if (!infl) mode = M_IDLE;
                end
            endcase
        end
        cyc = c + 1;
        while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
    endtask

    // One clock cycle: compare on the falling edge, advance the model on the rising edge.
    task automatic tick();
        @(negedge clk);
        if (checking) check_outputs();
        @(posedge clk);
        model_edge();
        checking = 1'b1;
        #1;
    endtask

    task automatic new_req(input int i);
        op[i] = 2'($urandom_range(3));
        a[i]  = 16'($urandom);
        b[i]  = ($urandom_range(3) == 0) ? 16'd0 : 16'($urandom);
    endtask

    // Accepted requesters immediately present a fresh request.
    task automatic run_stream(input int n);
        repeat (n) begin
            tick();
            if (acc_id >= 0) new_req(acc_id);
        end
    endtask

    // Accepted requesters drop valid.
    task automatic run_hold(input int n);
        repeat (n) begin
            tick();
            if (acc_id >= 0) v[acc_id] = 1'b0;
        end
    endtask

    task automatic stream_until(input int n_acc, input int limit);
        int got;
        got = 0;
        for (int t = 0; t < limit && got < n_acc; t++) begin
            tick();
            if (acc_id >= 0) begin
                got++;
                new_req(acc_id);
            end
        end
        chk("accept_budget", 32'(got), 32'(n_acc));
    endtask

    task automatic all_valid();
        for (int i = 0; i < N_REQ; i++) begin
            v[i] = 1'b1;
            new_req(i);
        end
    endtask

    task automatic drop_all();
        for (int i = 0; i < N_REQ; i++) v[i] = 1'b0;
    endtask

    initial begin
        compared = 0; mismatched = 0; cyc = 0; checking = 1'b0;
        mode = M_IDLE; last = N_REQ - 1; acc_id = -1;
        e_op = 2'b00; e_a = 16'd0; e_b = 16'd0;
        rst = 1'b1; en = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            v[i] = 1'b0; op[i] = 2'b00; a[i] = 16'd0; b[i] = 16'd0;
        end

        // Reset, then observe the idle state
        repeat (2) tick();
        rst = 1'b0;
        run_hold(2);

        // Single add from requester 0: 3 + 4
        en = 1'b1;
        v[0] = 1'b1; op[0] = 2'b00; a[0] = 16'd3; b[0] = 16'd4;
        run_hold(10);

        // Contention from reset: all four requesters streaming
        rst = 1'b1; tick(); rst = 1'b0;
        all_valid();
        run_stream(14);
        drop_all();
        run_hold(8);

        // Divide by zero from requester 2
        v[2] = 1'b1; op[2] = 2'b11; a[2] = 16'd10; b[2] = 16'd0;
        run_hold(9);

        // Drain: drop enable with three operations in flight
        all_valid();
        stream_until(3, 10);
        en = 1'b0;
        run_stream(10);
        drop_all();
        run_hold(2);

        // Reset one cycle after two acceptances; next grant restarts at 0
        en = 1'b1;
        all_valid();
        stream_until(2, 10);
        rst = 1'b1; tick(); rst = 1'b0;
        run_stream(6);
        drop_all();
        run_hold(8);

        // Fairness: pointer at 1, requesters 1 and 3 -> 3 then 1
        rst = 1'b1; tick(); rst = 1'b0;
        v[1] = 1'b1; new_req(1);
        run_hold(3);
        v[1] = 1'b1; new_req(1);
        v[3] = 1'b1; new_req(3);
        run_hold(10);

        // Random traffic with occasional enable toggles and resets
        repeat (1500) begin
            tick();
            for (int i = 0; i < N_REQ; i++) begin
                if (v[i] && acc_id == i) begin
                    v[i] = ($urandom_range(2) != 0);
                    new_req(i);
                end else if (!v[i] && $urandom_range(2) == 0) begin
                    v[i] = 1'b1;
                    new_req(i);
                end
            end
            if ($urandom_range(15) == 0) en = ~en;
            rst = ($urandom_range(127) == 0);
        end
        rst = 1'b0;
        drop_all();
        run_hold(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
